// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared FSM state type and counter-width helpers for the reset
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a saturating count 0..n.
  function automatic int sat_w(input int n);
    return cnt_w(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sequencer_if.sv
// ============================================================================
// Module      : rst_sequencer_if
// Description : Button/lock inputs and sequenced reset outputs of the reset
//               sequencer; slave is the sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);

  logic                   btn_in;
  logic                   locked;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_released;
  logic                   btn_req;

  modport master (
    output btn_in,
    output locked,
    input  dom_rst,
    input  all_released,
    input  btn_req
  );

  modport slave (
    input  btn_in,
    input  locked,
    output dom_rst,
    output all_released,
    output btn_req
  );

endinterface

`default_nettype wire

// File: rtl/rst_debounce.sv
// ============================================================================
// Module      : rst_debounce
// Description : Button synchroniser, sample prescaler and release debouncer
//               producing a registered, active-high reset request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int PRESCALE_W     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn_in_i,
  output logic      btn_req_o
);

  localparam int DB_W = sat_w(DEBOUNCE_TICKS);

  localparam logic            c_btn_asserted = (BTN_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [DB_W-1:0] c_db_max       = DB_W'(DEBOUNCE_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRESCALE_W-1:0]  pre_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   btn_req_q, btn_req_d;
  logic                   tick;
  logic                   sample_active;

  // Chain resets to the asserted raw level so a request is seen until the
  // button has been observed idle through the whole debounce window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{c_btn_asserted}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in_i};
    end
  end

  assign sample_active = (sync_q[SYNC_STAGES-1] == c_btn_asserted);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRESCALE_W'(1);
    end
  end

  assign tick = &pre_q;

  always_comb begin
    db_cnt_d  = db_cnt_q;
    btn_req_d = btn_req_q;
    if (tick) begin
      if (sample_active) begin
        db_cnt_d  = '0;
        btn_req_d = 1'b1;
      end else begin
        if (db_cnt_q != c_db_max) begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
        btn_req_d = (db_cnt_d != c_db_max);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      btn_req_q <= 1'b1;
    end else begin
      db_cnt_q  <= db_cnt_d;
      btn_req_q <= btn_req_d;
    end
  end

  assign btn_req_o = btn_req_q;

endmodule

`default_nettype wire

// File: rtl/rst_sequencer.sv
// ============================================================================
// Module      : rst_sequencer
// Description : Holds all reset domains until the button is debounced idle and
//               the clock is locked, then releases them one by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int PRESCALE_W     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int NUM_DOMAINS    = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input wire logic       clk,
  input wire logic       rst,
  rst_sequencer_if.slave bus
);

  localparam int IDX_W = cnt_w(NUM_DOMAINS);
  localparam int GAP_W = cnt_w(GAP_CYCLES);

  localparam logic [IDX_W-1:0]       c_idx_last = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [GAP_W-1:0]       c_gap_last = GAP_W'(GAP_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] c_all_held = '1;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_s;
  logic                   btn_req;
  logic                   abort;

  seq_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   all_rel_q, all_rel_d;

  rst_debounce #(
    .PRESCALE_W    (PRESCALE_W),
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_in_i (bus.btn_in),
    .btn_req_o(btn_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
    end
  end

  assign locked_s = lock_sync_q[SYNC_STAGES-1];
  assign abort    = btn_req || !locked_s;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    dom_rst_d = dom_rst_q;
    all_rel_d = all_rel_q;

    unique case (state_q)
      HOLD: begin
        dom_rst_d = c_all_held;
        all_rel_d = 1'b0;
        idx_d     = '0;
        gap_d     = '0;
        if (!abort) begin
          dom_rst_d = c_all_held << 1;
          if (NUM_DOMAINS == 1) begin
            state_d   = RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d = SEQ;
          end
        end
      end

      SEQ: begin
        if (abort) begin
          state_d   = HOLD;
          dom_rst_d = c_all_held;
          all_rel_d = 1'b0;
          idx_d     = '0;
          gap_d     = '0;
        end else if (gap_q == c_gap_last) begin
          // Masking keeps earlier domains released regardless of idx width.
          idx_d     = idx_q + IDX_W'(1);
          dom_rst_d = dom_rst_q & ~(NUM_DOMAINS'(1) << idx_d);
          gap_d     = '0;
          if (idx_d == c_idx_last) begin
            state_d   = RUN;
            all_rel_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (abort) begin
          state_d   = HOLD;
          dom_rst_d = c_all_held;
          all_rel_d = 1'b0;
          idx_d     = '0;
          gap_d     = '0;
        end else begin
          dom_rst_d = '0;
          all_rel_d = 1'b1;
        end
      end

      default: begin
        state_d   = HOLD;
        dom_rst_d = c_all_held;
        all_rel_d = 1'b0;
        idx_d     = '0;
        gap_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      gap_q     <= '0;
      dom_rst_q <= c_all_held;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      dom_rst_q <= dom_rst_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign bus.dom_rst      = dom_rst_q;
  assign bus.all_released = all_rel_q;
  assign bus.btn_req      = btn_req;

endmodule

`default_nettype wire
